if_stage: RTL and testbench

//  Instruction-fetch stage: produces the fetch PC, drives the synchronous inst SRAM, and presents {inst, pc} to the

---
 rtl/if_stage.sv | 129 ++++++++++++
 tb/tb_if_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch: generates nextpc, issues inst SRAM reads, hands {inst, pc} to decode.
// Latency: a request issued in cycle N is presented to decode in cycle N+1.
// Backpressure: ds_allowin low holds the IF slot; the SRAM word is parked in a 1-entry buffer.
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ds_allowin,
    input  logic [64:0]  br_bus,
    output logic         fs_to_ds_valid,
    output logic [95:0]  fs_to_ds_bus,
    output logic         inst_sram_en,
    output logic [63:0]  inst_sram_addr,
    input  logic [31:0]  inst_sram_rdata
);

    // Redirect request from decode; already qualified by decode's valid.
    typedef struct packed {
        logic        taken;
        logic [63:0] target;
    } br_t;

    // Payload handed to decode.
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } fs_ds_t;

    localparam logic [63:0] PC_STEP = 64'd4;

    br_t         br;
    fs_ds_t      fs_out;

    logic        started;
    logic        to_fs_valid;
    logic [63:0] seq_pc;
    logic [63:0] nextpc;

    logic        fs_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic [63:0] fs_pc;
    logic [31:0] fs_inst;

    logic [31:0] inst_buf;
    logic        buf_valid;
    logic        buf_capture;

    assign br = br_t'(br_bus);

    // ---------------------------------------------------------------
    // Pre-IF: the request side. Nothing is requested until the first
    // clock after reset release, so RESET_PC is the first address.
    // ---------------------------------------------------------------
    assign to_fs_valid = started;

    // Sequential PC wraps modulo 2^64; the branch target is taken as-is.
    assign seq_pc = fs_pc + PC_STEP;
    assign nextpc = br.taken ? br.target : seq_pc;

    // Mark that the first fetch may be issued once reset is released.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // IF slot. The SRAM answers in one cycle, so the stage is always
    // ready; it only advances when decode can take the current word.
    // ---------------------------------------------------------------
    assign fs_ready_go = 1'b1;
    assign fs_allowin  = !fs_valid || (fs_ready_go && ds_allowin);

    assign inst_sram_en   = to_fs_valid && fs_allowin;
    assign inst_sram_addr = nextpc;

    // Load the slot with the address requested this cycle, or drain it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - PC_STEP;
        end else if (to_fs_valid && fs_allowin) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
        end else if (fs_allowin) begin
            fs_valid <= 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Stall buffer. SRAM read data is only valid for the single cycle
    // after the request, so a stalled slot must park it. The first
    // captured word is kept until the instruction leaves; a later
    // capture would grab stale or unrelated read data. A wrong-path
    // word captured under a branch is dropped when the redirect loads,
    // since loading the slot always clears the buffer.
    // ---------------------------------------------------------------
    assign buf_capture = fs_valid && !buf_valid && !ds_allowin;

    // Park the SRAM word on the first stalled cycle; release it on departure.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_buf  <= 32'h0;
            buf_valid <= 1'b0;
        end else if (fs_allowin) begin
            buf_valid <= 1'b0;
        end else if (buf_capture) begin
            inst_buf  <= inst_sram_rdata;
            buf_valid <= 1'b1;
        end
    end

    assign fs_inst = buf_valid ? inst_buf : inst_sram_rdata;

    // ---------------------------------------------------------------
    // Output to decode. A taken branch means the word in IF is on the
    // wrong path, so it is never presented.
    // ---------------------------------------------------------------
    assign fs_out.inst = fs_inst;
    assign fs_out.pc   = fs_pc;

    assign fs_to_ds_valid = fs_valid && fs_ready_go && !br.taken;
    assign fs_to_ds_bus   = fs_out;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         ds_allowin = 1'b0;
    logic [64:0]  br_bus = '0;
    logic         fs_to_ds_valid;
    logic [95:0]  fs_to_ds_bus;
    logic         inst_sram_en;
    logic [63:0]  inst_sram_addr;
    logic [31:0]  inst_sram_rdata = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata)
    );

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_C3C3 ^ {a[39:32], 24'h0};
    endfunction

    // Synchronous SRAM: data one cycle after the request; garbage otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
        else              inst_sram_rdata <= 32'hDEAD_0000 | cyc[15:0];
    end

    typedef struct {
        logic        allow;
        logic        br_taken;
        logic [63:0] br_target;
        logic        exp_vld;
        logic [63:0] exp_pc;
        logic        exp_en;
        logic [63:0] exp_addr;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic allow, input logic bt, input logic [63:0] tgt,
                                input logic vld, input logic [63:0] pc,
                                input logic en, input logic [63:0] addr);
        vec_t v;
        v.allow = allow; v.br_taken = bt; v.br_target = tgt;
        v.exp_vld = vld; v.exp_pc = pc; v.exp_en = en; v.exp_addr = addr;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Apply rows lo..hi one per cycle; optionally release reset with the first row.
    task automatic run_rows(input int lo, input int hi, input bit rel);
        for (int i = lo; i <= hi; i++) begin
            @(posedge clk);
            #1;
            if (i == lo && rel) resetn = 1'b1;
            ds_allowin = vecs[i].allow;
            br_bus     = {vecs[i].br_taken, vecs[i].br_target};
            @(negedge clk);
            check("fs_to_ds_valid", i, {63'h0, fs_to_ds_valid}, {63'h0, vecs[i].exp_vld});
            check("inst_sram_en",   i, {63'h0, inst_sram_en},   {63'h0, vecs[i].exp_en});
            check("inst_sram_addr", i, inst_sram_addr, vecs[i].exp_addr);
            if (vecs[i].exp_vld) begin
                check("fs_pc",   i, fs_to_ds_bus[63:0], vecs[i].exp_pc);
                check("fs_inst", i, {32'h0, fs_to_ds_bus[95:64]}, {32'h0, mem_word(vecs[i].exp_pc)});
            end
        end
    endtask

    initial begin
        // Reset release and streaming fetch.
        vecs[0]  = mk(1, 0, 64'h0, 0, 64'h0, 0, 64'h8000_0000);
        vecs[1]  = mk(1, 0, 64'h0, 0, 64'h0, 1, 64'h8000_0000);
        vecs[2]  = mk(1, 0, 64'h0, 1, 64'h8000_0000, 1, 64'h8000_0004);
        vecs[3]  = mk(1, 0, 64'h0, 1, 64'h8000_0004, 1, 64'h8000_0008);
        // Decode stall for 3 cycles with garbage on rdata, then release.
        vecs[4]  = mk(0, 0, 64'h0, 1, 64'h8000_0008, 0, 64'h8000_000C);
        vecs[5]  = mk(0, 0, 64'h0, 1, 64'h8000_0008, 0, 64'h8000_000C);
        vecs[6]  = mk(0, 0, 64'h0, 1, 64'h8000_0008, 0, 64'h8000_000C);
        vecs[7]  = mk(1, 0, 64'h0, 1, 64'h8000_0008, 1, 64'h8000_000C);
        // One-cycle taken branch squashes 8000_000C.
        vecs[8]  = mk(1, 1, 64'h8000_0100, 0, 64'h0, 1, 64'h8000_0100);
        vecs[9]  = mk(1, 0, 64'h0, 1, 64'h8000_0100, 1, 64'h8000_0104);
        vecs[10] = mk(1, 0, 64'h0, 1, 64'h8000_0104, 1, 64'h8000_0108);
        // Branch held across a 2-cycle decode stall.
        vecs[11] = mk(0, 1, 64'h8000_0200, 0, 64'h0, 0, 64'h8000_0200);
        vecs[12] = mk(0, 1, 64'h8000_0200, 0, 64'h0, 0, 64'h8000_0200);
        vecs[13] = mk(1, 1, 64'h8000_0200, 0, 64'h0, 1, 64'h8000_0200);
        vecs[14] = mk(1, 0, 64'h0, 1, 64'h8000_0200, 1, 64'h8000_0204);
        vecs[15] = mk(1, 0, 64'h0, 1, 64'h8000_0204, 1, 64'h8000_0208);
        // PC wrap at the top of the address space.
        vecs[16] = mk(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        vecs[17] = mk(1, 0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h0);
        vecs[18] = mk(1, 0, 64'h0, 1, 64'h0, 1, 64'h4);
        vecs[19] = mk(1, 0, 64'h0, 1, 64'h4, 1, 64'h8);
        // Restart after a mid-stream reset pulse.
        vecs[20] = mk(1, 0, 64'h0, 0, 64'h0, 0, 64'h8000_0000);
        vecs[21] = mk(1, 0, 64'h0, 0, 64'h0, 1, 64'h8000_0000);
        vecs[22] = mk(1, 0, 64'h0, 1, 64'h8000_0000, 1, 64'h8000_0004);

        // Reset state.
        ds_allowin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst fs_to_ds_valid", -1, {63'h0, fs_to_ds_valid}, 64'h0);
        check("rst inst_sram_en",   -1, {63'h0, inst_sram_en},   64'h0);
        check("rst inst_sram_addr", -1, inst_sram_addr, RESET_PC);
        check("rst fs_pc",          -1, fs_to_ds_bus[63:0], RESET_PC - 64'd4);

        run_rows(0, 19, 1'b1);

        // Reset pulsed between edges: outputs drop without waiting for a clock.
        #2;
        resetn = 1'b0;
        #1;
        check("midrst fs_to_ds_valid", -2, {63'h0, fs_to_ds_valid}, 64'h0);
        check("midrst inst_sram_en",   -2, {63'h0, inst_sram_en},   64'h0);
        check("midrst inst_sram_addr", -2, inst_sram_addr, RESET_PC);
        check("midrst fs_pc",          -2, fs_to_ds_bus[63:0], RESET_PC - 64'd4);

        run_rows(20, 22, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
